// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared types and geometry helpers for the cache line fill controller.
// Geometry widths are derived from DATA_W and WORDS_PER_LINE at elaboration time.
package cache_line_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2
  } fill_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int bpw_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w, input int wpl);
    return clog2(wpl * (data_w / 8));
  endfunction

  function automatic int idx_w_of(input int wpl);
    return clog2(wpl);
  endfunction

endpackage

// File: rtl/cache_line_fill_ctrl_if.sv
// Shared memory port between the fill controller (master) and the memory arbiter (slave).
interface cache_line_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_grant;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  modport master (
    output mem_addr, mem_read_en, mem_write_en, mem_wdata,
    input  mem_grant, mem_rdata, mem_rdata_valid
  );

  modport slave (
    input  mem_addr, mem_read_en, mem_write_en, mem_wdata,
    output mem_grant, mem_rdata, mem_rdata_valid
  );
endinterface

// File: rtl/cache_line_fill_ctrl_counter.sv
// Saturating word counter: counts inc pulses up to LIMIT, clr has priority.
module cache_word_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         done
);
  assign done = (count == W'(LIMIT));

  always_ff @(posedge clk)
    if (rst || clr)       count <= '0;
    else if (inc && !done) count <= count + W'(1);
endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Miss handler: optional dirty-victim write-back, then a line fill with issues and
// returns counted independently; pulses write_tag_array once the whole line has landed.
module cache_line_fill_ctrl
  import cache_line_fill_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int WORDS_PER_LINE = 8,
  parameter bit WRITEBACK_EN   = 1'b1,
  localparam int BPW   = bpw_of(DATA_W),
  localparam int OFF_W = off_w_of(DATA_W, WORDS_PER_LINE),
  localparam int IDX_W = idx_w_of(WORDS_PER_LINE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_detected,
  input  logic                    miss_dirty,
  input  logic [ADDR_W-1:0]       miss_address,
  input  logic [ADDR_W-OFF_W-1:0] victim_tag,
  input  logic [DATA_W-1:0]       victim_rdata,
  output logic [IDX_W-1:0]        victim_word_idx,
  output logic                    fsm_busy,
  output logic                    write_data_array,
  output logic [IDX_W-1:0]        fill_word_idx,
  output logic [DATA_W-1:0]       write_cache_data,
  output logic                    write_tag_array,
  cache_line_fill_ctrl_if.master  mem
);
  localparam int CNT_W = IDX_W + 1;

  fill_state_e      state, state_nxt;
  logic [CNT_W-1:0] iss_cnt, ret_cnt;
  logic             iss_done, ret_done, iss_inc, ret_inc, cnt_clr;
  logic [OFF_W-1:0] word_off;
  logic             unused_addr_bits;

  always_ff @(posedge clk)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  cache_word_counter #(.W(CNT_W), .LIMIT(WORDS_PER_LINE)) u_iss_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(iss_inc), .count(iss_cnt), .done(iss_done)
  );

  cache_word_counter #(.W(CNT_W), .LIMIT(WORDS_PER_LINE)) u_ret_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(ret_inc), .count(ret_cnt), .done(ret_done)
  );

  // Fixed-width offset: word index scaled to bytes never carries into the tag.
  assign word_off         = OFF_W'(iss_cnt[IDX_W-1:0]) * OFF_W'(BPW);
  assign cnt_clr          = (state_nxt != state);
  assign mem.mem_wdata    = victim_rdata;
  assign write_cache_data = mem.mem_rdata;
  assign unused_addr_bits = ^miss_address[OFF_W-1:0];

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    write_tag_array  = 1'b0;
    write_data_array = 1'b0;
    iss_inc          = 1'b0;
    ret_inc          = 1'b0;
    victim_word_idx  = '0;
    fill_word_idx    = '0;
    mem.mem_read_en  = 1'b0;
    mem.mem_write_en = 1'b0;
    mem.mem_addr     = '0;
    case (state)
      ST_IDLE: begin
        if (miss_detected) begin
          fsm_busy  = 1'b1;
          state_nxt = (miss_dirty && WRITEBACK_EN) ? ST_EVICT : ST_FILL;
        end
      end
      ST_EVICT: begin
        fsm_busy        = 1'b1;
        victim_word_idx = iss_cnt[IDX_W-1:0];
        mem.mem_addr    = {victim_tag, word_off};
        if (!iss_done) begin
          mem.mem_write_en = 1'b1;
          iss_inc          = mem.mem_grant;
          if (mem.mem_grant && iss_cnt == CNT_W'(WORDS_PER_LINE - 1)) state_nxt = ST_FILL;
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        fill_word_idx = ret_cnt[IDX_W-1:0];
        mem.mem_addr  = {miss_address[ADDR_W-1:OFF_W], word_off};
        if (ret_done) begin
          // Completion cycle: a new miss here is deliberately not sampled.
          write_tag_array = 1'b1;
          state_nxt       = ST_IDLE;
        end else begin
          fsm_busy         = 1'b1;
          mem.mem_read_en  = !iss_done;
          iss_inc          = mem.mem_grant && !iss_done;
          ret_inc          = mem.mem_rdata_valid && mem.mem_grant;
          write_data_array = ret_inc;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench: three controller configurations share one memory model; only the
// selected instance ever sees miss_detected, so the others stay idle.
module tb_cache_line_fill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        miss_detected = 1'b0, miss_dirty = 1'b0;
  logic [15:0] miss_address = '0;
  logic [11:0] victim_tag = '0;
  logic        mem_grant = 1'b0, mem_rdata_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          sel = 0;

  logic [2:0]  vwi_a, fwi_a, vwi_b, fwi_b;
  logic [1:0]  vwi_c, fwi_c;
  logic        busy_a, wda_a, wta_a, busy_b, wda_b, wta_b, busy_c, wda_c, wta_c;
  logic [15:0] wcd_a, wcd_b, vrd_a, vrd_b;
  logic [31:0] wcd_c, vrd_c;

  cache_line_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  cache_line_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) ifb ();
  cache_line_fill_ctrl_if #(.ADDR_W(16), .DATA_W(32)) ifc ();

  assign ifa.mem_grant = mem_grant;
  assign ifa.mem_rdata = mem_rdata[15:0];
  assign ifa.mem_rdata_valid = mem_rdata_valid;
  assign ifb.mem_grant = mem_grant;
  assign ifb.mem_rdata = mem_rdata[15:0];
  assign ifb.mem_rdata_valid = mem_rdata_valid;
  assign ifc.mem_grant = mem_grant;
  assign ifc.mem_rdata = mem_rdata;
  assign ifc.mem_rdata_valid = mem_rdata_valid;

  // Victim data array: word i holds a recognisable pattern.
  assign vrd_a = 16'h5A00 + {13'h0, vwi_a};
  assign vrd_b = 16'h5A00 + {13'h0, vwi_b};
  assign vrd_c = 32'h5A5A_0000 + {30'h0, vwi_c};

  cache_line_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(8), .WRITEBACK_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .miss_detected(miss_detected && sel == 0), .miss_dirty(miss_dirty),
    .miss_address(miss_address), .victim_tag(victim_tag), .victim_rdata(vrd_a),
    .victim_word_idx(vwi_a), .fsm_busy(busy_a), .write_data_array(wda_a), .fill_word_idx(fwi_a),
    .write_cache_data(wcd_a), .write_tag_array(wta_a), .mem(ifa));

  cache_line_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_LINE(8), .WRITEBACK_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .miss_detected(miss_detected && sel == 1), .miss_dirty(miss_dirty),
    .miss_address(miss_address), .victim_tag(victim_tag), .victim_rdata(vrd_b),
    .victim_word_idx(vwi_b), .fsm_busy(busy_b), .write_data_array(wda_b), .fill_word_idx(fwi_b),
    .write_cache_data(wcd_b), .write_tag_array(wta_b), .mem(ifb));

  cache_line_fill_ctrl #(.ADDR_W(16), .DATA_W(32), .WORDS_PER_LINE(4), .WRITEBACK_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .miss_detected(miss_detected && sel == 2), .miss_dirty(miss_dirty),
    .miss_address(miss_address), .victim_tag(victim_tag), .victim_rdata(vrd_c),
    .victim_word_idx(vwi_c), .fsm_busy(busy_c), .write_data_array(wda_c), .fill_word_idx(fwi_c),
    .write_cache_data(wcd_c), .write_tag_array(wta_c), .mem(ifc));

  typedef struct {logic [15:0] addr; logic [31:0] data; logic [2:0] idx;} wr_t;
  typedef struct {logic [2:0] idx; logic [31:0] data;} fl_t;
  typedef struct {int rdy; logic [15:0] addr;} pd_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  fl_t         exp_fill[$];
  pd_t         pend[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, wpl = 8, bpw = 2;
  logic wb_en = 1'b1;
  int grant_mode = 0, gap_max = 0;
  int tag_cnt = 0, tag_cyc = 0, fill_cnt = 0, last_fill_cyc = 0, launch_cyc = 0, miss_hold = 0;
  logic spur_en = 0, spur_pending = 0, ret_now = 0, first_rd_chk = 0;
  logic req_miss = 0, chain_arm = 0, chain_go = 0, restart_chk = 0;
  logic [15:0] req_addr = '0, chain_addr = '0;

  logic        obs_busy, obs_wda, obs_wta, obs_rd, obs_wr;
  logic [2:0]  obs_fwi, obs_vwi;
  logic [31:0] obs_wcd, obs_wdata;
  logic [15:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rdat(input logic [15:0] a);
    return {~a, a ^ 16'hC3C3};
  endfunction

  function automatic logic [31:0] msk(input logic [31:0] v);
    return (sel == 2) ? v : {16'h0, v[15:0]};
  endfunction

  function automatic logic [31:0] vdat(input int i);
    return (sel == 2) ? 32'h5A5A_0000 + 32'(i) : 32'h0000_5A00 + 32'(i);
  endfunction

  task automatic use_dut(input int s);
    sel   = s;
    wpl   = (s == 2) ? 4 : 8;
    bpw   = (s == 2) ? 4 : 2;
    wb_en = (s != 1);
  endtask

  task automatic push_exp(input logic [15:0] a, input logic wb, input logic [11:0] vt);
    logic [15:0] base, ra;
    wr_t w;
    fl_t f;
    base = a & ~16'(wpl * bpw - 1);
    if (wb)
      for (int i = 0; i < wpl; i++) begin
        w.addr = {vt, 4'h0} + 16'(i * bpw);
        w.data = vdat(i);
        w.idx  = 3'(i);
        exp_wr.push_back(w);
      end
    for (int i = 0; i < wpl; i++) begin
      ra = base + 16'(i * bpw);
      exp_rd.push_back(ra);
      f.idx  = 3'(i);
      f.data = msk(rdat(ra));
      exp_fill.push_back(f);
    end
  endtask

  task automatic sample();
    case (sel)
      0: begin
        obs_busy = busy_a; obs_wda = wda_a; obs_wta = wta_a; obs_fwi = fwi_a; obs_vwi = vwi_a;
        obs_wcd = {16'h0, wcd_a}; obs_addr = ifa.mem_addr; obs_rd = ifa.mem_read_en;
        obs_wr = ifa.mem_write_en; obs_wdata = {16'h0, ifa.mem_wdata};
      end
      1: begin
        obs_busy = busy_b; obs_wda = wda_b; obs_wta = wta_b; obs_fwi = fwi_b; obs_vwi = vwi_b;
        obs_wcd = {16'h0, wcd_b}; obs_addr = ifb.mem_addr; obs_rd = ifb.mem_read_en;
        obs_wr = ifb.mem_write_en; obs_wdata = {16'h0, ifb.mem_wdata};
      end
      default: begin
        obs_busy = busy_c; obs_wda = wda_c; obs_wta = wta_c; obs_fwi = {1'b0, fwi_c};
        obs_vwi = {1'b0, vwi_c}; obs_wcd = wcd_c; obs_addr = ifc.mem_addr;
        obs_rd = ifc.mem_read_en; obs_wr = ifc.mem_write_en; obs_wdata = ifc.mem_wdata;
      end
    endcase
  endtask

  task automatic monitor();
    wr_t w;
    fl_t f;
    pd_t p;
    logic [15:0] a;
    chk("rd_wr_overlap", {31'h0, obs_rd & obs_wr}, 32'h0);
    if (obs_wr && mem_grant) begin
      if (exp_wr.size() == 0) chk("wb_extra", {31'h0, obs_wr}, 32'h0);
      else begin
        w = exp_wr.pop_front();
        chk("wb_addr", {16'h0, obs_addr}, {16'h0, w.addr});
        chk("wb_data", obs_wdata, w.data);
        chk("wb_vidx", {29'h0, obs_vwi}, {29'h0, w.idx});
      end
    end
    if (obs_rd) chk("rd_before_wb_done", 32'(exp_wr.size()), 32'h0);
    if (first_rd_chk && obs_rd) begin
      chk("first_rd_lat", 32'(cyc - launch_cyc), 32'd1);
      first_rd_chk = 1'b0;
    end
    if (obs_rd && mem_grant) begin
      if (exp_rd.size() == 0) chk("rd_extra", {31'h0, obs_rd}, 32'h0);
      else begin
        a = exp_rd.pop_front();
        chk("rd_addr", {16'h0, obs_addr}, {16'h0, a});
      end
      p.rdy  = cyc + 1 + int'($urandom_range(gap_max, 0));
      p.addr = obs_addr;
      pend.push_back(p);
    end
    if (ret_now && mem_grant) begin
      void'(pend.pop_front());
      if (spur_en && pend.size() == 0 && exp_rd.size() == 0) spur_pending = 1'b1;
    end
    if (obs_wda) begin
      if (exp_fill.size() == 0) chk("fill_extra", {31'h0, obs_wda}, 32'h0);
      else begin
        f = exp_fill.pop_front();
        chk("fill_idx", {29'h0, obs_fwi}, {29'h0, f.idx});
        chk("fill_data", obs_wcd, f.data);
      end
      fill_cnt++;
      last_fill_cyc = cyc;
      if (chain_arm && exp_fill.size() == 0) begin chain_go = 1'b1; chain_arm = 1'b0; end
    end
    if (obs_wta) begin
      tag_cnt++;
      tag_cyc = cyc;
      chk("tag_latency", 32'(cyc - last_fill_cyc), 32'd1);
      chk("tag_busy_low", {31'h0, obs_busy}, 32'h0);
    end
    if (restart_chk && cyc == tag_cyc + 1) begin
      chk("restart_busy", {31'h0, obs_busy}, 32'h1);
      chk("restart_idle_rd", {31'h0, obs_rd}, 32'h0);
    end
    if (restart_chk && obs_rd) begin
      chk("restart_lat", 32'(cyc - tag_cyc), 32'd2);
      restart_chk = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    ret_now = 1'b0;
    if (spur_pending) begin
      mem_grant = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      spur_pending = 1'b0;
    end else begin
      mem_grant = (grant_mode == 0) || (cyc % 2 == 0);
      if (pend.size() != 0 && pend[0].rdy <= cyc) begin
        mem_rdata_valid = 1'b1; mem_rdata = rdat(pend[0].addr); ret_now = 1'b1;
      end else begin
        mem_rdata_valid = 1'b0; mem_rdata = '0;
      end
    end
    if (req_miss) begin
      miss_detected = 1'b1; miss_address = req_addr; miss_hold = 1; req_miss = 1'b0;
      launch_cyc = cyc;
    end else if (chain_go) begin
      miss_detected = 1'b1; miss_address = chain_addr; miss_hold = 1; chain_go = 1'b0;
      push_exp(chain_addr, miss_dirty && wb_en, victim_tag);
      restart_chk = 1'b1;
    end else if (miss_hold > 0) miss_hold--;
    else miss_detected = 1'b0;
    @(negedge clk);
    sample();
    monitor();
  endtask

  task automatic run_miss(input logic [15:0] a, input logic dirty, input logic [11:0] vt,
                          input int gmode, input int gmax, input logic spur,
                          input logic chain, input logic [15:0] ca);
    int exp_tags;
    grant_mode = gmode; gap_max = gmax; spur_en = spur;
    tag_cnt = 0; fill_cnt = 0; restart_chk = 1'b0;
    miss_dirty = dirty; victim_tag = vt;
    push_exp(a, dirty && wb_en, vt);
    first_rd_chk = !(dirty && wb_en);
    chain_arm = chain; chain_addr = ca;
    exp_tags = chain ? 2 : 1;
    req_miss = 1'b1; req_addr = a;
    tick();
    chk("busy_on_miss", {31'h0, obs_busy}, 32'h1);
    for (int n = 0; n < 600 && tag_cnt < exp_tags; n++) tick();
    repeat (4) tick();
    chk("tag_count", 32'(tag_cnt), 32'(exp_tags));
    chk("wb_left", 32'(exp_wr.size()), 32'h0);
    chk("rd_left", 32'(exp_rd.size()), 32'h0);
    chk("fill_left", 32'(exp_fill.size()), 32'h0);
    chk("idle_busy", {31'h0, obs_busy}, 32'h0);
    exp_wr.delete(); exp_rd.delete(); exp_fill.delete(); pend.delete();
  endtask

  initial begin
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      use_dut(s);
      sample();
      chk("rst_busy", {31'h0, obs_busy}, 32'h0);
      chk("rst_tag", {31'h0, obs_wta}, 32'h0);
      chk("rst_rd", {31'h0, obs_rd}, 32'h0);
      chk("rst_wr", {31'h0, obs_wr}, 32'h0);
      chk("rst_wda", {31'h0, obs_wda}, 32'h0);
      chk("rst_idx", {26'h0, obs_fwi, obs_vwi}, 32'h0);
    end
    rst = 1'b0;
    tick();

    use_dut(0);
    run_miss(16'h1234, 1'b0, 12'h000, 0, 0, 1'b0, 1'b0, 16'h0);
    run_miss(16'h2468, 1'b1, 12'hABC, 0, 0, 1'b0, 1'b0, 16'h0);
    run_miss(16'h5678, 1'b0, 12'h000, 1, 4, 1'b1, 1'b0, 16'h0);

    // Abort a fill with rst after three returns; in-flight data must be dropped.
    grant_mode = 0; gap_max = 0; spur_en = 1'b0; miss_dirty = 1'b0;
    tag_cnt = 0; fill_cnt = 0; first_rd_chk = 1'b0;
    push_exp(16'h0200, 1'b0, victim_tag);
    req_miss = 1'b1; req_addr = 16'h0200;
    for (int n = 0; n < 100 && fill_cnt < 3; n++) tick();
    chk("abort_pre_fills", 32'(fill_cnt), 32'd3);
    exp_rd.delete(); exp_fill.delete();
    rst = 1'b1;
    tick();
    chk("abort_busy", {31'h0, obs_busy}, 32'h0);
    chk("abort_rd", {31'h0, obs_rd}, 32'h0);
    chk("abort_tag", {31'h0, obs_wta}, 32'h0);
    rst = 1'b0;
    for (int n = 0; n < 20 && pend.size() != 0; n++) tick();
    repeat (2) tick();
    chk("abort_no_tag", 32'(tag_cnt), 32'h0);
    chk("abort_drained", 32'(pend.size()), 32'h0);
    run_miss(16'h0040, 1'b0, 12'h000, 0, 0, 1'b0, 1'b0, 16'h0);

    use_dut(1);
    run_miss(16'h0A10, 1'b1, 12'h123, 0, 0, 1'b0, 1'b0, 16'h0);

    use_dut(2);
    run_miss(16'h3458, 1'b0, 12'h000, 0, 0, 1'b0, 1'b1, 16'h0040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
